// File: rtl/fp_mac_pkg.sv
// Shared types and helpers for the floating-point MAC datapath.
// Holds the operand class enum, default half-precision field widths and the class decode.
package fp_mac_pkg;

    localparam int FP_EXP_W_DEF = 5;
    localparam int FP_MAN_W_DEF = 10;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_SUB,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    // Takes reduced field predicates so the same decode serves any exponent/mantissa width.
    function automatic fp_class_e fp_class_of(
        input logic exp_is_zero,
        input logic exp_is_ones,
        input logic man_is_zero
    );
        if (exp_is_zero) begin
            return man_is_zero ? FP_ZERO : FP_SUB;
        end
        if (exp_is_ones) begin
            return man_is_zero ? FP_INF : FP_NAN;
        end
        return FP_NORM;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Per-operand classifier: class, effective exponent and significand with hidden bit.
// Define FP_MUL_FTZ_EN to flush subnormal operands to zero instead of unpacking them.
module fp_classify
    import fp_mac_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W_DEF,
    parameter int MAN_W = FP_MAN_W_DEF
) (
    input  logic [EXP_W-1:0] i_exp,
    input  logic [MAN_W-1:0] i_man,
    output fp_class_e        o_class,
    output logic [EXP_W-1:0] o_eff_exp,
    output logic [MAN_W:0]   o_sig
);

    fp_class_e w_class_raw;

    always_comb begin
        w_class_raw = fp_class_of(i_exp == '0, i_exp == '1, i_man == '0);
        o_class     = w_class_raw;
        o_eff_exp   = '0;
        o_sig       = '0;
        case (w_class_raw)
            FP_SUB: begin
`ifdef FP_MUL_FTZ_EN
                o_class   = FP_ZERO;
`else
                // Subnormals share the smallest normal exponent but have no hidden one.
                o_eff_exp = EXP_W'(1);
                o_sig     = {1'b0, i_man};
`endif
            end
            FP_NORM: begin
                o_eff_exp = i_exp;
                o_sig     = {1'b1, i_man};
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/fp_mul_unpack_pipe.sv
// Two-stage operand unpack/classify pipeline feeding the FP multiplier significand path.
// Define FP_MUL_FTZ_EN to flush subnormal inputs to zero in stage 1.
module fp_mul_unpack_pipe
    import fp_mac_pkg::*;
#(
    parameter  int EXP_W = FP_EXP_W_DEF,
    parameter  int MAN_W = FP_MAN_W_DEF,
    localparam int BIAS  = (1 << (EXP_W - 1)) - 1,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     num_a,
    input  logic [W-1:0]     num_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W+1:0] out_exp,
    output logic [MAN_W:0]   out_man_a,
    output logic [MAN_W:0]   out_man_b,
    output logic             out_zero,
    output logic             out_inf,
    output logic             out_nan
);

    fp_class_e        w_cls_a;
    fp_class_e        w_cls_b;
    logic [EXP_W-1:0] w_eff_a;
    logic [EXP_W-1:0] w_eff_b;
    logic [MAN_W:0]   w_sig_a;
    logic [MAN_W:0]   w_sig_b;

    logic             w_s1_adv;
    logic             w_s2_adv;

    logic             r_s1_valid;
    logic             r_s1_sign;
    fp_class_e        r_s1_cls_a;
    fp_class_e        r_s1_cls_b;
    logic [EXP_W-1:0] r_s1_eff_a;
    logic [EXP_W-1:0] r_s1_eff_b;
    logic [MAN_W:0]   r_s1_sig_a;
    logic [MAN_W:0]   r_s1_sig_b;

    logic             w_nan;
    logic             w_inf;
    logic             w_zero;
    logic [EXP_W+1:0] w_exp;
    logic [MAN_W:0]   w_man_a;
    logic [MAN_W:0]   w_man_b;

    logic             r_s2_valid;
    logic             r_out_sign;
    logic [EXP_W+1:0] r_out_exp;
    logic [MAN_W:0]   r_out_man_a;
    logic [MAN_W:0]   r_out_man_b;
    logic             r_out_zero;
    logic             r_out_inf;
    logic             r_out_nan;

    fp_classify #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_classify_a (
        .i_exp     (num_a[W-2 -: EXP_W]),
        .i_man     (num_a[MAN_W-1:0]),
        .o_class   (w_cls_a),
        .o_eff_exp (w_eff_a),
        .o_sig     (w_sig_a)
    );

    fp_classify #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_classify_b (
        .i_exp     (num_b[W-2 -: EXP_W]),
        .i_man     (num_b[MAN_W-1:0]),
        .o_class   (w_cls_b),
        .o_eff_exp (w_eff_b),
        .o_sig     (w_sig_b)
    );

    // Backpressure ripples from the output register; in_ready never looks at in_valid.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_cls_a <= FP_ZERO;
            r_s1_cls_b <= FP_ZERO;
            r_s1_eff_a <= '0;
            r_s1_eff_b <= '0;
            r_s1_sig_a <= '0;
            r_s1_sig_b <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign  <= num_a[W-1] ^ num_b[W-1];
                r_s1_cls_a <= w_cls_a;
                r_s1_cls_b <= w_cls_b;
                r_s1_eff_a <= w_eff_a;
                r_s1_eff_b <= w_eff_b;
                r_s1_sig_a <= w_sig_a;
                r_s1_sig_b <= w_sig_b;
            end
        end
    end

    // Class priority is NaN, then Inf, then zero, which keeps the three flags one-hot.
    always_comb begin
        w_nan   = (r_s1_cls_a == FP_NAN) || (r_s1_cls_b == FP_NAN)
               || ((r_s1_cls_a == FP_INF) && (r_s1_cls_b == FP_ZERO))
               || ((r_s1_cls_a == FP_ZERO) && (r_s1_cls_b == FP_INF));
        w_inf   = !w_nan && ((r_s1_cls_a == FP_INF) || (r_s1_cls_b == FP_INF));
        w_zero  = !w_nan && !w_inf
               && ((r_s1_cls_a == FP_ZERO) || (r_s1_cls_b == FP_ZERO));
        w_exp   = '0;
        w_man_a = '0;
        w_man_b = '0;
        if (!(w_nan || w_inf || w_zero)) begin
            w_exp   = {2'b00, r_s1_eff_a} + {2'b00, r_s1_eff_b} - (EXP_W+2)'(BIAS);
            w_man_a = r_s1_sig_a;
            w_man_b = r_s1_sig_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_out_sign  <= 1'b0;
            r_out_exp   <= '0;
            r_out_man_a <= '0;
            r_out_man_b <= '0;
            r_out_zero  <= 1'b0;
            r_out_inf   <= 1'b0;
            r_out_nan   <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_sign  <= r_s1_sign;
                r_out_exp   <= w_exp;
                r_out_man_a <= w_man_a;
                r_out_man_b <= w_man_b;
                r_out_zero  <= w_zero;
                r_out_inf   <= w_inf;
                r_out_nan   <= w_nan;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_sign  = r_out_sign;
    assign out_exp   = r_out_exp;
    assign out_man_a = r_out_man_a;
    assign out_man_b = r_out_man_b;
    assign out_zero  = r_out_zero;
    assign out_inf   = r_out_inf;
    assign out_nan   = r_out_nan;

endmodule
